// File: rtl/bloom_pkg.sv
// Shared hash definitions for the Bloom filter: three hash functions over the
// key, reduced to a filter bit index, plus a per-bit mask helper.
package bloom_pkg;

  localparam int unsigned NUM_HASH = 3;

  // Hash arithmetic is carried in a fixed 64-bit container; keys up to 56 bits
  // keep 5*d + (d >> 3) from overflowing it before the explicit reduction.
  localparam int unsigned CALC_W = 64;
  localparam int unsigned MAX_DATA_W = 56;

  // Index of the n-th hash for key d (zero-extended to CALC_W). The result is
  // reduced mod 2^(dw+4) and then mod 2^idx_w, which collapses to keeping the
  // low min(dw+4, idx_w) bits.
  function automatic int unsigned hash_idx(
    input logic [CALC_W-1:0] d,
    input int unsigned       n,
    input int unsigned       dw,
    input int unsigned       idx_w
  );
    logic [CALC_W-1:0] h;
    logic [CALC_W-1:0] keep_mask;
    int unsigned       keep;
    case (n)
      0:       h = d;
      1:       h = CALC_W'(3) * d + CALC_W'(5);
      2:       h = CALC_W'(5) * d + (d >> 3);
      default: h = '0;
    endcase
    keep      = (dw + 4 < idx_w) ? dw + 4 : idx_w;
    keep_mask = (CALC_W'(1) << keep) - CALC_W'(1);
    return 32'(h & keep_mask);
  endfunction

  // One bit of mask(d): set when any of the NUM_HASH indices lands on pos.
  function automatic logic mask_bit(
    input logic [CALC_W-1:0] d,
    input int unsigned       dw,
    input int unsigned       idx_w,
    input int unsigned       pos
  );
    logic hit;
    hit = 1'b0;
    for (int unsigned n = 0; n < NUM_HASH; n++) begin
      if (hash_idx(d, n, dw, idx_w) == pos) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/bloom_hash.sv
// Combinational key -> FILTER_SIZE-bit hash mask (up to NUM_HASH bits set;
// colliding indices simply set fewer bits).
module bloom_hash
  import bloom_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned FILTER_SIZE = 32
) (
  input  logic [DATA_WIDTH-1:0]  data,
  output logic [FILTER_SIZE-1:0] mask
);

  localparam int unsigned IDX_W = $clog2(FILTER_SIZE);

  logic [CALC_W-1:0] data_ext;

  assign data_ext = CALC_W'(data);

  // Build the mask one filter bit at a time from the package helper.
  always_comb begin
    mask = '0;
    for (int unsigned i = 0; i < FILTER_SIZE; i++) begin
      mask[i] = mask_bit(data_ext, DATA_WIDTH, IDX_W, i);
    end
  end

endmodule

// File: rtl/bloom_filter.sv
// Bloom filter membership pre-filter: insert sets the key's hash bits, check
// reports (one cycle later) whether all of them were already set.
module bloom_filter
  import bloom_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,   // 1..MAX_DATA_W
  parameter int unsigned FILTER_SIZE = 32   // power of two, >= 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  data,
  input  logic                   insert,
  input  logic                   check,
  output logic                   match,
  output logic [FILTER_SIZE-1:0] bl_out
);

  logic [FILTER_SIZE-1:0] mask;
  logic                   all_set;

  bloom_hash #(
    .DATA_WIDTH  (DATA_WIDTH),
    .FILTER_SIZE (FILTER_SIZE)
  ) u_hash (
    .data (data),
    .mask (mask)
  );

  // Query compares against the register value before this edge, so a
  // same-cycle insert of a new key does not make its own check hit.
  assign all_set = ((bl_out & mask) == mask);

  // Filter array and registered query result; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      bl_out <= '0;
      match  <= 1'b0;
    end else begin
      if (insert) bl_out <= bl_out | mask;
      match <= check & all_set;
    end
  end

endmodule

// File: tb/tb_bloom_filter.sv
// Directed, table-driven bench for bloom_filter (DATA_WIDTH=8, FILTER_SIZE=32).
module tb_bloom_filter;

  localparam int unsigned DW = 8;
  localparam int unsigned FS = 32;

  logic          clk;
  logic          reset;
  logic [DW-1:0] data;
  logic          insert;
  logic          check;
  logic          match;
  logic [FS-1:0] bl_out;

  int checks;
  int errors;

  bloom_filter #(
    .DATA_WIDTH  (DW),
    .FILTER_SIZE (FS)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .data   (data),
    .insert (insert),
    .check  (check),
    .match  (match),
    .bl_out (bl_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          ins;
    logic          chk;
    logic [DW-1:0] d;
    logic [FS-1:0] exp_bl;
    logic          exp_m;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic ins, input logic chk,
                              input logic [DW-1:0] d, input logic [FS-1:0] exp_bl,
                              input logic exp_m);
    vec_t v;
    v.rst = rst; v.ins = ins; v.chk = chk; v.d = d;
    v.exp_bl = exp_bl; v.exp_m = exp_m;
    return v;
  endfunction

  task automatic cmp_bl(input string name, input logic [FS-1:0] act, input logic [FS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: bl_out=0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic cmp_m(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: match=%b expected %b", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs away from the edge, then sample after the edge.
  task automatic step(input logic rst, input logic ins, input logic chk, input logic [DW-1:0] d);
    @(negedge clk);
    reset = rst; insert = ins; check = chk; data = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; insert = 1'b0; check = 1'b0; data = '0;
    checks = 0; errors = 0;

    // Reset priority, insert sequence, queries, same-cycle insert+check.
    vecs.push_back(mk(1, 1, 0, 8'd10,  32'h0000_0000, 0));
    vecs.push_back(mk(1, 1, 0, 8'd10,  32'h0000_0000, 0));
    vecs.push_back(mk(0, 1, 0, 8'd10,  32'h0008_0408, 0));
    vecs.push_back(mk(0, 1, 0, 8'd52,  32'h0018_040A, 0));
    vecs.push_back(mk(0, 1, 0, 8'd200, 32'h2018_050A, 0));
    vecs.push_back(mk(0, 1, 0, 8'd79,  32'h201C_850A, 0));
    vecs.push_back(mk(0, 1, 0, 8'd52,  32'h201C_850A, 0));
    vecs.push_back(mk(0, 0, 1, 8'd60,  32'h201C_850A, 0));
    vecs.push_back(mk(0, 0, 1, 8'd52,  32'h201C_850A, 1));
    vecs.push_back(mk(0, 0, 1, 8'd52,  32'h201C_850A, 1));
    vecs.push_back(mk(0, 0, 0, 8'd52,  32'h201C_850A, 0));
    vecs.push_back(mk(0, 0, 1, 8'd200, 32'h201C_850A, 1));
    vecs.push_back(mk(1, 0, 0, 8'd0,   32'h0000_0000, 0));
    vecs.push_back(mk(0, 1, 1, 8'd79,  32'h0014_8000, 0));
    vecs.push_back(mk(0, 0, 1, 8'd79,  32'h0014_8000, 1));
    vecs.push_back(mk(0, 0, 1, 8'd10,  32'h0014_8000, 0));
    vecs.push_back(mk(0, 1, 1, 8'd79,  32'h0014_8000, 1));
    vecs.push_back(mk(1, 0, 1, 8'd79,  32'h0000_0000, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].ins, vecs[i].chk, vecs[i].d);
      cmp_bl($sformatf("vec%0d_bl", i), bl_out, vecs[i].exp_bl);
      cmp_m($sformatf("vec%0d_match", i), match, vecs[i].exp_m);
    end

    // Saturation: h0 = d, so inserting 0..31 sets every bit; then any query hits.
    step(1, 0, 0, 8'd0);
    for (int k = 0; k < 32; k++) step(0, 1, 0, DW'(k));
    cmp_bl("saturate_bl", bl_out, 32'hFFFF_FFFF);
    step(0, 0, 1, 8'd60);
    cmp_m("saturate_match60", match, 1'b1);
    step(0, 0, 1, 8'd255);
    cmp_m("saturate_match255", match, 1'b1);
    step(0, 0, 0, 8'd255);
    cmp_m("saturate_idle", match, 1'b0);

    // Held insert of one key is idempotent across many cycles.
    step(1, 0, 0, 8'd0);
    for (int k = 0; k < 4; k++) step(0, 1, 0, 8'd200);
    cmp_bl("hold_insert_bl", bl_out, 32'h2000_0102);
    step(0, 0, 1, 8'd200);
    cmp_m("hold_insert_match", match, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
